heavy_part_ram_arbiter: RTL and testbench
=========================================

Name: heavy_part_ram_arbiter

Overview:
- Shares the single port of one heavy-part bucket RAM between two requesters.
- The read requester is the table-read stage, which fetches the bucket at hash address [79:68].
- The write requester is the update/write-back stage, which returns the modified bucket.
- After reset it clears the RAM, then arbitrates: write-back priority, with a bounded burst so reads are never starved.

Parameters:
ADDR_W, 12, RAM address width (4096 buckets)
DATA_W, 96, bucket width ([95:64] key, [63:32] value, [31:0] counter)
WR_BURST_MAX, 4, max consecutive write grants while a read is pending (range 1..15)
INIT_CLEAR, 1, 1 = zero-fill the RAM after reset; 0 = skip straight to run

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
rd_req  in  1  read request; held with rd_addr until rd_ack
rd_addr  in  ADDR_W  read bucket address
rd_ack  out  1  read granted this cycle (combinational)
wr_req  in  1  write-back request; held with wr_addr/wr_data until wr_ack
wr_addr  in  ADDR_W  write bucket address
wr_data  in  DATA_W  write bucket data
wr_ack  out  1  write granted this cycle (combinational)
ram_rden  out  1  RAM read enable (registered)
ram_wren  out  1  RAM write enable (registered)
ram_addr  out  ADDR_W  RAM address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
init_done  out  1  high once clearing is finished; requests are accepted only then

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on port reset.
- Reset values: all registered outputs are 0, init_done=0, state=init_s (or run_s with init_done=1 when INIT_CLEAR=0), clear counter=0, burst counter=0.
- Reset mid-operation: aborts any grant or clear. After release, clearing restarts from address 0.

State init_s:
- rd_ack=0 and wr_ack=0 regardless of requests.
- Each cycle drives ram_wren=1, ram_addr=clear counter, ram_wdata=0, ram_rden=0, then increments the counter.
- After address 4095 is issued: next cycle ram_wren=0, init_done=1, state=run_s.
- Clear therefore takes exactly 4096 write cycles. init_done rises in the cycle after the last clear write is visible.

State run_s (grant is combinational from registered state):
- Write priority: wr_ack = wr_req & ~force_rd.
- rd_ack = rd_req & (~wr_req | force_rd).
- force_rd = (burst counter == WR_BURST_MAX) & rd_req.
- Never rd_ack & wr_ack in the same cycle.

Burst counter:
- Increments on each wr_ack while rd_req=1, saturating at WR_BURST_MAX.
- Cleared on rd_ack, or in any cycle with rd_req=0.

RAM drive:
- Latency: 1 cycle from ack to the RAM strobe.
- On a grant at cycle N, the RAM signals are registered in cycle N+1.
  - Write: ram_wren=1, ram_addr=wr_addr, ram_wdata=wr_data.
  - Read: ram_rden=1, ram_addr=rd_addr.
- With no grant: ram_rden=0 and ram_wren=0. ram_addr and ram_wdata hold their last value.

Ordering and throughput:
- Same address requested by both in the same cycle: the write is granted first, so the later read returns the updated bucket (read-after-write safe).
- One grant per cycle at most; back-to-back grants are allowed every cycle.
- Requesters may present their next request in the cycle after ack.
- No internal buffering: payload must be stable while req=1 and ack=0.

Decomposition:
- Shared package heavy_part_pkg holds:
  - HP_ADDR_W=12, HP_DATA_W=96;
  - bucket field offsets (key [95:64], value [63:32], counter [31:0]);
  - state encodings init_s=1'b0, run_s=1'b1.
- No sub-module: the block is a single FSM plus the clear counter and burst counter.

Test Plan:
- Clear sequence: release reset, INIT_CLEAR=1.
  -> 4096 consecutive ram_wren pulses, addr 0..4095, wdata 0.
  -> init_done rises on the next cycle.
  -> rd_req held high during the clear gets no rd_ack.
- Simple read: after init, rd_req=1, rd_addr=12'h0A5, no write.
  -> rd_ack same cycle; next cycle ram_rden=1, ram_addr=12'h0A5, ram_wren=0.
- Same-address collision: wr_req and rd_req both at addr 12'h123, wr_data=96'h1.
  -> wr_ack first; next cycle ram_wren=1, addr 12'h123.
  -> rd_ack the following cycle, then ram_rden=1 at 12'h123.
- Starvation bound: wr_req continuous, rd_req continuous, WR_BURST_MAX=4.
  -> repeating grant pattern W,W,W,W,R.
  -> exactly 4 ram_wren pulses between consecutive ram_rden pulses.
- Reset mid-operation: assert reset at clear counter 2000, then release.
  -> all registered outputs 0 immediately.
  -> clear restarts at address 0 and completes after 4096 cycles.
- Idle bubbles: alternate rd_req pulses with one idle cycle between them.
  -> ram_rden toggles 1,0,1,0 and ram_addr holds its value during idle cycles.

Source files
------------

// File: rtl/heavy_part_pkg.sv
// Shared definitions for the heavy-part bucket RAM: geometry, bucket field layout
// and the arbiter state encoding.
package heavy_part_pkg;

    localparam int HP_ADDR_W = 12;
    localparam int HP_DATA_W = 96;

    // Bucket layout: {key, value, counter}
    localparam int HP_KEY_MSB = 95;
    localparam int HP_KEY_LSB = 64;
    localparam int HP_VAL_MSB = 63;
    localparam int HP_VAL_LSB = 32;
    localparam int HP_CNT_MSB = 31;
    localparam int HP_CNT_LSB = 0;

    typedef enum logic {
        init_s = 1'b0,
        run_s  = 1'b1
    } state_t;

endpackage

// File: rtl/heavy_part_ram_arbiter.sv
// Single-port bucket RAM arbiter: zero-fills the RAM after reset, then grants the
// write-back stage first, with a bounded write burst so the table-read stage is never starved.
module heavy_part_ram_arbiter
    import heavy_part_pkg::*;
#(
    parameter int ADDR_W       = HP_ADDR_W,
    parameter int DATA_W       = HP_DATA_W,
    parameter int WR_BURST_MAX = 4,
    parameter int INIT_CLEAR   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              ram_rden,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              init_done
);

    localparam int                 BURST_W     = 4;
    localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(WR_BURST_MAX);

    state_t              state;
    logic [ADDR_W:0]     clear_cnt;   // extra MSB marks "all addresses issued"
    logic [BURST_W-1:0]  burst_cnt;
    logic                running;
    logic                force_rd;

    // NOTE: every signal assigned here gets a value on every path, so no latch can form.
    always_comb begin
        running  = (state == run_s);
        force_rd = (burst_cnt == BURST_LIMIT) && rd_req;
        wr_ack   = running && wr_req && !force_rd;
        rd_ack   = running && rd_req && (!wr_req || force_rd);
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= (INIT_CLEAR != 0) ? init_s : run_s;
            init_done <= (INIT_CLEAR == 0);
            clear_cnt <= '0;
            burst_cnt <= '0;
            ram_rden  <= 1'b0;
            ram_wren  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_rden <= 1'b0;
            ram_wren <= 1'b0;
            if (state == init_s) begin
                if (clear_cnt[ADDR_W]) begin
                    state     <= run_s;
                    init_done <= 1'b1;
                end else begin
                    ram_wren  <= 1'b1;
                    ram_addr  <= clear_cnt[ADDR_W-1:0];
                    ram_wdata <= '0;
                    clear_cnt <= clear_cnt + 1'b1;
                end
            end else begin
                if (wr_ack) begin
                    ram_wren  <= 1'b1;
                    ram_addr  <= wr_addr;
                    ram_wdata <= wr_data;
                end else if (rd_ack) begin
                    ram_rden <= 1'b1;
                    ram_addr <= rd_addr;
                end
                // Counts writes that overtook a waiting read; saturation triggers force_rd.
                if (rd_ack || !rd_req)
                    burst_cnt <= '0;
                else if (wr_ack && burst_cnt != BURST_LIMIT)
                    burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_heavy_part_ram_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared every
// cycle against a behavioural model of the clear sequence and the bounded write priority.
module tb_heavy_part_ram_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 96;
    localparam int BURST = 4;
    localparam int CLEAR = 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req, wr_req;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_ack, wr_ack, ram_rden, ram_wren, init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;

    int checks = 0;
    int errors = 0;

    heavy_part_ram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WR_BURST_MAX(BURST), .INIT_CLEAR(CLEAR)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_rden(ram_rden), .ram_wren(ram_wren), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .init_done(init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Clearing: addresses 0..DEPTH-1 are written one per cycle, then one quiet cycle
    // raises init_done. Running: writes win unless the waiting read has already seen
    // BURST writes go past it; the RAM strobe shows the previous cycle's winner.
    bit            m_clearing, m_init_done;
    int            m_clear_next, m_streak;
    logic          m_rden, m_wren;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;

    task automatic model_reset();
        m_clearing   = (CLEAR != 0);
        m_init_done  = (CLEAR == 0);
        m_clear_next = 0;
        m_streak     = 0;
        m_rden       = 1'b0;
        m_wren       = 1'b0;
        m_addr       = '0;
        m_wdata      = '0;
    endtask

    always @(negedge clk) begin
        bit e_rd, e_wr, overdue;
        if (!reset) begin
            model_reset();
            check("rst_rden", ram_rden, 0);
            check("rst_wren", ram_wren, 0);
            check("rst_addr", ram_addr, 0);
            check("rst_wdata", ram_wdata, 0);
            check("rst_init_done", init_done, m_init_done);
        end else begin
            e_rd = 1'b0;
            e_wr = 1'b0;
            if (!m_clearing) begin
                overdue = rd_req && (m_streak >= BURST);
                e_wr    = wr_req && !overdue;
                e_rd    = rd_req && !e_wr;
            end
            check("rd_ack", rd_ack, e_rd);
            check("wr_ack", wr_ack, e_wr);
            check("ram_rden", ram_rden, m_rden);
            check("ram_wren", ram_wren, m_wren);
            check("ram_addr", ram_addr, m_addr);
            check("ram_wdata", ram_wdata, m_wdata);
            check("init_done", init_done, m_init_done);
            if (m_clearing) begin
                m_rden = 1'b0;
                if (m_clear_next < DEPTH) begin
                    m_wren  = 1'b1;
                    m_addr  = AW'(m_clear_next);
                    m_wdata = '0;
                    m_clear_next++;
                end else begin
                    m_wren      = 1'b0;
                    m_clearing  = 1'b0;
                    m_init_done = 1'b1;
                end
            end else begin
                m_rden = e_rd;
                m_wren = e_wr;
                if (e_wr) begin
                    m_addr  = wr_addr;
                    m_wdata = wr_data;
                end else if (e_rd) begin
                    m_addr = rd_addr;
                end
                if (!rd_req || e_rd)
                    m_streak = 0;
                else if (e_wr && m_streak < BURST)
                    m_streak++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int n, wr_n;
        logic [AW-1:0] first_addr;
        n = 0;
        wr_n = 0;
        first_addr = '1;
        while (n < 5000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) first_addr = ram_addr;
            if (ram_wren) wr_n++;
            if (init_done) break;
        end
        if (!init_done) begin
            errors++;
            $display("FAIL %s_timeout: init_done never rose within %0d cycles", name, n);
        end
        check({name, "_cycles"}, n, DEPTH + 1);
        check({name, "_writes"}, wr_n, DEPTH);
        check({name, "_first_addr"}, first_addr, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, nrd, n;
        bit gr, gw;
        logic [AW-1:0] a_prev;
        logic [AW-1:0] bub [4];

        reset = 1'b0;
        rd_req = 1'b0; wr_req = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        repeat (3) step();

        // Clear sequence with a read held high throughout.
        rd_req  = 1'b1;
        rd_addr = 12'h7FF;
        reset   = 1'b1;
        wait_init("clear");
        step();
        rd_req = 1'b0;
        @(negedge clk);
        check("held_read_rden", ram_rden, 1);
        check("held_read_addr", ram_addr, 12'h7FF);
        step();

        // Simple read.
        rd_req  = 1'b1;
        rd_addr = 12'h0A5;
        @(negedge clk);
        check("simple_rd_ack", rd_ack, 1);
        step();
        rd_req = 1'b0;
        @(negedge clk);
        check("simple_rden", ram_rden, 1);
        check("simple_addr", ram_addr, 12'h0A5);
        check("simple_wren", ram_wren, 0);
        step();

        // Same-address collision: write first, then read.
        rd_req = 1'b1; rd_addr = 12'h123;
        wr_req = 1'b1; wr_addr = 12'h123; wr_data = 96'h1;
        @(negedge clk);
        check("coll_wr_ack", wr_ack, 1);
        check("coll_rd_ack0", rd_ack, 0);
        step();
        wr_req = 1'b0;
        @(negedge clk);
        check("coll_wren", ram_wren, 1);
        check("coll_waddr", ram_addr, 12'h123);
        check("coll_wdata", ram_wdata, 96'h1);
        check("coll_rd_ack1", rd_ack, 1);
        step();
        rd_req = 1'b0;
        @(negedge clk);
        check("coll_rden", ram_rden, 1);
        check("coll_raddr", ram_addr, 12'h123);
        step();

        // Starvation bound: both requesters saturated.
        gap = 0;
        nrd = 0;
        rd_req = 1'b1; rd_addr = AW'($urandom);
        wr_req = 1'b1; wr_addr = AW'($urandom); wr_data = {$urandom, $urandom, $urandom};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ram_rden) begin
                check("burst_gap", gap, BURST);
                gap = 0;
                nrd++;
            end
            if (ram_wren) gap++;
            gr = rd_ack;
            gw = wr_ack;
            step();
            if (gw) begin
                wr_addr = AW'($urandom);
                wr_data = {$urandom, $urandom, $urandom};
            end
            if (gr) rd_addr = AW'($urandom);
        end
        check("burst_reads", nrd, 7);
        rd_req = 1'b0;
        wr_req = 1'b0;
        step();

        // Idle bubbles between single reads.
        bub[0] = 12'h010; bub[1] = 12'hABC; bub[2] = 12'h3F0; bub[3] = 12'hFFF;
        a_prev = '0;
        for (int i = 0; i < 4; i++) begin
            rd_req  = 1'b1;
            rd_addr = bub[i];
            @(negedge clk);
            if (i > 0) begin
                check("bubble_idle_rden", ram_rden, 0);
                check("bubble_idle_addr", ram_addr, a_prev);
            end
            step();
            rd_req = 1'b0;
            @(negedge clk);
            check("bubble_rden", ram_rden, 1);
            check("bubble_addr", ram_addr, bub[i]);
            a_prev = bub[i];
            step();
        end

        // Randomized traffic obeying the hold-until-ack protocol.
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            gr = rd_ack;
            gw = wr_ack;
            step();
            if (!rd_req || gr) begin
                rd_req  = ($urandom_range(0, 99) < 60);
                rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            end
            if (!wr_req || gw) begin
                wr_req  = ($urandom_range(0, 99) < 70);
                wr_addr = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom);
                wr_data = {$urandom, $urandom, $urandom};
            end
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        step();

        // Reset in the middle of a clear, then a full restart.
        reset = 1'b0;
        step();
        reset = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ram_wren && ram_addr == 12'd2000) && n < 3000);
        check("midrst_reached_2000", ram_addr, 12'd2000);
        #1 reset = 1'b0;
        #1;
        check("midrst_wren", ram_wren, 0);
        check("midrst_addr", ram_addr, 0);
        check("midrst_init_done", init_done, 0);
        step();
        step();
        reset = 1'b1;
        wait_init("reclear");

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
